// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: three-requester arbiter in front of a single-port-per-direction RAM.
//
// Ports:
//   clk, rst_n                  clock (rising edge) and asynchronous active-low reset
//   req_x, wr_x, addr_x, wdata_x requester x access request, type (1 = write), address, data
//   gnt_x                       combinational accept; a transfer is req_x && gnt_x
//   rvalid_x                    qp holds read data for requester x (2 cycles after grant)
//   qp                          RAM read data, consumed directly by the requesters
//   we_p, re_p                  registered RAM write/read enables
//   write_addressp, read_addressp, dp  registered RAM addresses and write data
//   busy                        a read is somewhere in the owner tag pipeline
//
// Optional feature: define RAM_ARB_FIXED_PRIO_EN to give requester 0 absolute priority,
// with requesters 1 and 2 round-robining between themselves.
module ram_port_arbiter #(
  parameter int SIZE_1           = 0,
  parameter int SIZE_address_pix = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_0,
  input  logic                        req_1,
  input  logic                        req_2,
  input  logic                        wr_0,
  input  logic                        wr_1,
  input  logic                        wr_2,
  input  logic [SIZE_address_pix-1:0] addr_0,
  input  logic [SIZE_address_pix-1:0] addr_1,
  input  logic [SIZE_address_pix-1:0] addr_2,
  input  logic [SIZE_1-1:0]           wdata_0,
  input  logic [SIZE_1-1:0]           wdata_1,
  input  logic [SIZE_1-1:0]           wdata_2,
  output logic                        gnt_0,
  output logic                        gnt_1,
  output logic                        gnt_2,
  output logic                        rvalid_0,
  output logic                        rvalid_1,
  output logic                        rvalid_2,
  input  logic [SIZE_1-1:0]           qp,
  output logic                        we_p,
  output logic                        re_p,
  output logic [SIZE_address_pix-1:0] write_addressp,
  output logic [SIZE_address_pix-1:0] read_addressp,
  output logic [SIZE_1-1:0]           dp,
  output logic                        busy
);

  logic [2:0]                  req_v;
  logic [2:0]                  gnt_v;
  logic [1:0]                  gnt_idx;
  logic                        xfer;
  logic                        sel_wr;
  logic [SIZE_address_pix-1:0] sel_addr;
  logic [SIZE_1-1:0]           sel_wdata;

  logic [1:0]                  rr_q, rr_d;
  logic                        we_q, we_d, re_q, re_d;
  logic [SIZE_address_pix-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic [SIZE_1-1:0]           dp_q, dp_d;
  // Owner tag pipeline: stage 1 lines up with re_p, stage 2 with valid qp.
  logic                        t1_vld_q, t1_vld_d, t2_vld_q, t2_vld_d;
  logic [1:0]                  t1_own_q, t1_own_d, t2_own_q, t2_own_d;

  // Read data goes straight from the RAM to the requesters; the arbiter never looks at it.
  logic unused_qp;
  assign unused_qp = ^qp;

  assign req_v = {req_2, req_1, req_0};

  // Grant selection; gnt_v is one-hot or zero.
  always_comb begin
    gnt_v   = 3'b000;
    gnt_idx = 2'd0;
`ifdef RAM_ARB_FIXED_PRIO_EN
    if (req_v[0]) begin
      gnt_idx = 2'd0;
    end else if (rr_q == 2'd2) begin
      gnt_idx = req_v[2] ? 2'd2 : 2'd1;
    end else begin
      gnt_idx = req_v[1] ? 2'd1 : 2'd2;
    end
`else
    case (rr_q)
      2'd1:    gnt_idx = req_v[1] ? 2'd1 : (req_v[2] ? 2'd2 : 2'd0);
      2'd2:    gnt_idx = req_v[2] ? 2'd2 : (req_v[0] ? 2'd0 : 2'd1);
      default: gnt_idx = req_v[0] ? 2'd0 : (req_v[1] ? 2'd1 : 2'd2);
    endcase
`endif
    // gnt_idx only falls through to a non-requesting port when nobody requests.
    if (req_v[gnt_idx] && rst_n) begin
      gnt_v[gnt_idx] = 1'b1;
    end
  end

  assign {gnt_2, gnt_1, gnt_0} = gnt_v;
  assign xfer = |gnt_v;

  always_comb begin
    sel_wr    = wr_0;
    sel_addr  = addr_0;
    sel_wdata = wdata_0;
    case (gnt_idx)
      2'd1: begin
        sel_wr    = wr_1;
        sel_addr  = addr_1;
        sel_wdata = wdata_1;
      end
      2'd2: begin
        sel_wr    = wr_2;
        sel_addr  = addr_2;
        sel_wdata = wdata_2;
      end
      default: ;
    endcase
  end

  always_comb begin
    rr_d     = rr_q;
    we_d     = 1'b0;
    re_d     = 1'b0;
    waddr_d  = waddr_q;
    raddr_d  = raddr_q;
    dp_d     = dp_q;
    t1_vld_d = 1'b0;
    t1_own_d = 2'd0;
    t2_vld_d = t1_vld_q;
    t2_own_d = t1_own_q;
    if (xfer) begin
      rr_d = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
      if (sel_wr) begin
        we_d    = 1'b1;
        waddr_d = sel_addr;
        dp_d    = sel_wdata;
      end else begin
        re_d     = 1'b1;
        raddr_d  = sel_addr;
        t1_vld_d = 1'b1;
        t1_own_d = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q     <= 2'd0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      waddr_q  <= '0;
      raddr_q  <= '0;
      dp_q     <= '0;
      t1_vld_q <= 1'b0;
      t1_own_q <= 2'd0;
      t2_vld_q <= 1'b0;
      t2_own_q <= 2'd0;
    end else begin
      rr_q     <= rr_d;
      we_q     <= we_d;
      re_q     <= re_d;
      waddr_q  <= waddr_d;
      raddr_q  <= raddr_d;
      dp_q     <= dp_d;
      t1_vld_q <= t1_vld_d;
      t1_own_q <= t1_own_d;
      t2_vld_q <= t2_vld_d;
      t2_own_q <= t2_own_d;
    end
  end

  assign we_p           = we_q;
  assign re_p           = re_q;
  assign write_addressp = waddr_q;
  assign read_addressp  = raddr_q;
  assign dp             = dp_q;
  assign rvalid_0       = t2_vld_q && (t2_own_q == 2'd0);
  assign rvalid_1       = t2_vld_q && (t2_own_q == 2'd1);
  assign rvalid_2       = t2_vld_q && (t2_own_q == 2'd2);
  assign busy           = t1_vld_q | t2_vld_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural synchronous RAM and a read
// scoreboard keyed on the cycle each read result is due.
module tb_ram_port_arbiter;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_0, req_1, req_2, wr_0, wr_1, wr_2;
  logic [AW-1:0] addr_0, addr_1, addr_2;
  logic [DW-1:0] wdata_0, wdata_1, wdata_2;
  logic          gnt_0, gnt_1, gnt_2, rvalid_0, rvalid_1, rvalid_2;
  logic [DW-1:0] qp, dp;
  logic          we_p, re_p, busy;
  logic [AW-1:0] write_addressp, read_addressp;

  ram_port_arbiter #(.SIZE_1(DW), .SIZE_address_pix(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .req_1(req_1), .req_2(req_2),
    .wr_0(wr_0), .wr_1(wr_1), .wr_2(wr_2),
    .addr_0(addr_0), .addr_1(addr_1), .addr_2(addr_2),
    .wdata_0(wdata_0), .wdata_1(wdata_1), .wdata_2(wdata_2),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .gnt_2(gnt_2),
    .rvalid_0(rvalid_0), .rvalid_1(rvalid_1), .rvalid_2(rvalid_2),
    .qp(qp), .we_p(we_p), .re_p(re_p),
    .write_addressp(write_addressp), .read_addressp(read_addressp),
    .dp(dp), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: one-cycle synchronous read.
  logic [DW-1:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (we_p) mem[write_addressp] <= dp;
    if (re_p) qp <= mem[read_addressp];
  end

  typedef struct {
    int          owner;
    logic [DW-1:0] data;
    int          due;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] ref_mem [16];
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Read-return checker.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        chk("rvalid_owner", {29'd0, rvalid_2, rvalid_1, rvalid_0}, 32'(1 << sb[0].owner));
        chk("rdata", 32'(qp), 32'(sb[0].data));
        void'(sb.pop_front());
      end else if ({rvalid_2, rvalid_1, rvalid_0} !== 3'b000) begin
        chk("rvalid_spurious", {29'd0, rvalid_2, rvalid_1, rvalid_0}, 32'd0);
      end
    end
  end

  // One cycle: drive requests, check the grant, then check the registered RAM side.
  task automatic tick(input logic [2:0] req, input logic [2:0] wr, input int exp_g);
    logic [2:0]    exp_v;
    logic          exp_we, exp_re;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    {req_2, req_1, req_0} = req;
    {wr_2, wr_1, wr_0}    = wr;
    #1;
    exp_v = (exp_g < 0) ? 3'b000 : 3'(1 << exp_g);
    chk("gnt", {29'd0, gnt_2, gnt_1, gnt_0}, {29'd0, exp_v});
    exp_we = 1'b0;
    exp_re = 1'b0;
    a = '0;
    d = '0;
    if (exp_g >= 0) begin
      case (exp_g)
        1:       begin a = addr_1; d = wdata_1; end
        2:       begin a = addr_2; d = wdata_2; end
        default: begin a = addr_0; d = wdata_0; end
      endcase
      if (wr[exp_g]) begin
        exp_we     = 1'b1;
        ref_mem[a] = d;
      end else begin
        exp_re = 1'b1;
        sb.push_back('{owner: exp_g, data: ref_mem[a], due: cyc + 2});
      end
    end
    @(posedge clk);
    #1;
    chk("we_p", 32'(we_p), 32'(exp_we));
    chk("re_p", 32'(re_p), 32'(exp_re));
    if (exp_we) begin
      chk("write_addressp", 32'(write_addressp), 32'(a));
      chk("dp", 32'(dp), 32'(d));
    end
    if (exp_re) chk("read_addressp", 32'(read_addressp), 32'(a));
    {req_2, req_1, req_0} = 3'b000;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    rst_n = 1'b0;
    {req_2, req_1, req_0} = 3'b000;
    {wr_2, wr_1, wr_0}    = 3'b000;
    addr_0 = '0; addr_1 = '0; addr_2 = '0;
    wdata_0 = '0; wdata_1 = '0; wdata_2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we_p", 32'(we_p), 32'd0);
    chk("rst_re_p", 32'(re_p), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rvalid", {29'd0, rvalid_2, rvalid_1, rvalid_0}, 32'd0);
    rst_n = 1'b1;

    // All three requesting: strict rotation 0,1,2,0,1,2 (port 0 writes, 1 and 2 read).
    addr_0 = 4'd1; wdata_0 = 8'hA0; addr_1 = 4'd1; addr_2 = 4'd2;
    tick(3'b111, 3'b001, 0);
    tick(3'b111, 3'b001, 1);
    tick(3'b111, 3'b001, 2);
    wdata_0 = 8'hA5;
    tick(3'b111, 3'b001, 0);
    tick(3'b111, 3'b001, 1);
    tick(3'b111, 3'b001, 2);

    // Write from 1 then immediate read of the same address from 2.
    addr_1 = 4'd5; wdata_1 = 8'h3C;
    tick(3'b010, 3'b010, 1);
    addr_2 = 4'd5;
    tick(3'b100, 3'b000, 2);

    // Four back-to-back reads from port 0.
    for (int i = 0; i < 4; i++) begin
      addr_0 = 4'(i);
      tick(3'b001, 3'b000, 0);
    end

    // Idle for 10 cycles; pointer must still favour port 1 afterwards.
    repeat (10) tick(3'b000, 3'b000, -1);
    addr_1 = 4'd6; wdata_1 = 8'h55;
    tick(3'b111, 3'b010, 1);

    // Reset one cycle after a read grant: the read is dropped.
    addr_1 = 4'd6;
    tick(3'b010, 3'b000, 1);
    sb.delete();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_re_p", 32'(re_p), 32'd0);
    chk("rst_mid_we_p", 32'(we_p), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    {req_2, req_1, req_0} = 3'b111;
    #1;
    chk("rst_mid_gnt", {29'd0, gnt_2, gnt_1, gnt_0}, 32'd0);
    {req_2, req_1, req_0} = 3'b000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) tick(3'b000, 3'b000, -1);
    tick(3'b110, 3'b000, 1);

    // Ports 0 and 2 contending (pointer now at 2).
    addr_0 = 4'd7; wdata_0 = 8'h99; addr_2 = 4'd6;
`ifdef RAM_ARB_FIXED_PRIO_EN
    repeat (4) tick(3'b101, 3'b001, 0);
`else
    tick(3'b101, 3'b001, 2);
    tick(3'b101, 3'b001, 0);
    tick(3'b101, 3'b001, 2);
    tick(3'b101, 3'b001, 0);
`endif
    tick(3'b100, 3'b000, 2);

    // Mixed back-to-back: write then read of same address from port 0.
    addr_0 = 4'd9; wdata_0 = 8'h6E;
    tick(3'b001, 3'b001, 0);
    tick(3'b001, 3'b000, 0);

    repeat (4) tick(3'b000, 3'b000, -1);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
